// File: rtl/mem_access_unit.sv
// Memory-access stage: maps byte/half/word loads and stores onto a word RAM, merging sub-word
// stores and splitting word-boundary-crossing accesses into two RAM cycles.
module mem_access_unit #(
  parameter int unsigned LEN = 10
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           req_valid,
  output logic           req_ready,
  input  logic           req_we,
  input  logic [1:0]     req_size,
  input  logic           req_unsigned,
  input  logic [31:0]    req_addr,
  input  logic [31:0]    req_wdata,
  input  logic [4:0]     req_rd,
  output logic           resp_valid,
  output logic [31:0]    resp_rdata,
  output logic [4:0]     resp_rd,
  output logic           resp_err,
  output logic           ram_we,
  output logic [LEN-1:0] ram_w_addr,
  output logic [LEN-1:0] ram_r_addr,
  output logic [31:0]    ram_din,
  input  logic [31:0]    ram_w_data,
  input  logic [31:0]    ram_r_data
);

  typedef enum logic [0:0] {StIdle, StSecond} state_e;

  state_e state_q, state_d;

  logic [LEN-1:0] idx_q;
  logic [1:0]     off_q;
  logic [1:0]     size_q;
  logic [31:0]    wdata_q;
  logic [4:0]     rd_q;
  logic           we_q;
  logic           uns_q;
  logic [31:0]    lo_q;

  logic           resp_valid_q;
  logic [31:0]    resp_rdata_q;
  logic [4:0]     resp_rd_q;
  logic           resp_err_q;

  logic           in_second;
  logic           accept;
  logic           illegal;
  logic           crossing;
  logic [LEN-1:0] cur_idx;
  logic [1:0]     cur_off;
  logic [1:0]     cur_size;
  logic [31:0]    cur_wdata;
  logic           cur_uns;
  logic [3:0]     cur_bmask;
  logic [7:0]     span;
  logic [63:0]    wdata_sh;
  logic [3:0]     wr_mask;
  logic [31:0]    wr_bytes;
  logic [31:0]    rd_lo;
  logic [31:0]    rd_hi;
  logic [63:0]    rd_sh;
  logic [31:0]    raw;
  logic [31:0]    ext;

  assign in_second = (state_q == StSecond);
  assign illegal   = (req_size == 2'b11);
  assign accept    = req_valid && req_ready;

  // In SECOND the latched request drives the shared datapath; in IDLE the live request does.
  assign cur_idx   = in_second ? idx_q   : req_addr[LEN+1:2];
  assign cur_off   = in_second ? off_q   : req_addr[1:0];
  assign cur_size  = in_second ? size_q  : req_size;
  assign cur_wdata = in_second ? wdata_q : req_wdata;
  assign cur_uns   = in_second ? uns_q   : req_unsigned;

  always_comb begin
    cur_bmask = 4'b0000;
    unique case (cur_size)
      2'b00:   cur_bmask = 4'b0001;
      2'b01:   cur_bmask = 4'b0011;
      2'b10:   cur_bmask = 4'b1111;
      default: cur_bmask = 4'b0000;
    endcase
  end

  // Byte lanes over two consecutive words: low nibble = word idx, high nibble = word idx+1.
  assign span     = {4'b0000, cur_bmask} << cur_off;
  assign crossing = !in_second && (|span[7:4]);

  assign wdata_sh = {32'b0, cur_wdata} << {cur_off, 3'b000};
  assign wr_mask  = in_second ? span[7:4] : span[3:0];
  assign wr_bytes = in_second ? wdata_sh[63:32] : wdata_sh[31:0];

  always_comb begin
    ram_din = '0;
    for (int i = 0; i < 4; i++) begin
      ram_din[8*i +: 8] = wr_mask[i] ? wr_bytes[8*i +: 8] : ram_w_data[8*i +: 8];
    end
  end

  assign rd_lo = in_second ? lo_q : ram_r_data;
  assign rd_hi = in_second ? ram_r_data : 32'b0;
  assign rd_sh = {rd_hi, rd_lo} >> {cur_off, 3'b000};
  assign raw   = rd_sh[31:0];

  always_comb begin
    ext = raw;
    unique case (cur_size)
      2'b00:   ext = cur_uns ? {24'b0, raw[7:0]}  : {{24{raw[7]}}, raw[7:0]};
      2'b01:   ext = cur_uns ? {16'b0, raw[15:0]} : {{16{raw[15]}}, raw[15:0]};
      default: ext = raw;
    endcase
  end

  // FSM: state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (accept && crossing) state_d = StSecond;
      StSecond: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // FSM: outputs
  always_comb begin
    req_ready  = !rst && (state_q == StIdle);
    ram_we     = 1'b0;
    ram_w_addr = cur_idx;
    ram_r_addr = cur_idx;
    if (!rst) begin
      if (in_second) ram_we = we_q;
      else           ram_we = accept && req_we && !illegal;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q        <= '0;
      off_q        <= '0;
      size_q       <= '0;
      wdata_q      <= '0;
      rd_q         <= '0;
      we_q         <= 1'b0;
      uns_q        <= 1'b0;
      lo_q         <= '0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_rd_q    <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      resp_valid_q <= 1'b0;
      if (!in_second && accept) begin
        if (illegal) begin
          resp_valid_q <= 1'b1;
          resp_err_q   <= 1'b1;
          resp_rdata_q <= '0;
          resp_rd_q    <= req_rd;
        end else if (crossing) begin
          idx_q   <= req_addr[LEN+1:2] + LEN'(1);
          off_q   <= req_addr[1:0];
          size_q  <= req_size;
          wdata_q <= req_wdata;
          rd_q    <= req_rd;
          we_q    <= req_we;
          uns_q   <= req_unsigned;
          lo_q    <= ram_r_data;
        end else if (!req_we) begin
          resp_valid_q <= 1'b1;
          resp_err_q   <= 1'b0;
          resp_rdata_q <= ext;
          resp_rd_q    <= req_rd;
        end
      end else if (in_second && !we_q) begin
        resp_valid_q <= 1'b1;
        resp_err_q   <= 1'b0;
        resp_rdata_q <= ext;
        resp_rd_q    <= rd_q;
      end
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_rd    = resp_rd_q;
  assign resp_err   = resp_err_q;

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Memory-access stage between the EX/MEM pipeline register and the data `RAM` (word-wide write port with async readback at `w_addr`, async read port at `r_addr`). It turns byte/half/word loads and stores into word RAM accesses and merges sub-word stores with the current RAM contents via `w_data`. It extracts and sign/zero-extends load data and splits accesses that cross a word boundary into two RAM cycles under a small FSM. Load results are registered toward writeback.

## Interface
- `LEN`, 10, RAM word-address width; must match the data `RAM`'s `LEN`.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  access request present.
- `req_ready`  out  1  unit can accept; combinational: `!rst && state==IDLE`.
- `req_we`  in  1  1 = store, 0 = load.
- `req_size`  in  2  00 byte, 01 half, 10 word, 11 illegal.
- `req_unsigned`  in  1  load zero-extends (lbu/lhu); ignored for stores/word.
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  store data, LSB-aligned.
- `req_rd`  in  5  load destination register tag.
- `resp_valid`  out  1  registered one-cycle pulse: load data or error ready.
- `resp_rdata`  out  32  extended load data.
- `resp_rd`  out  5  echoed `req_rd`.
- `resp_err`  out  1  qualifies `resp_valid`: illegal size.
- `ram_we`  out  1  to `RAM.we`.
- `ram_w_addr`  out  LEN  to `RAM.w_addr`.
- `ram_r_addr`  out  LEN  to `RAM.r_addr`.
- `ram_din`  out  32  to `RAM.din`.
- `ram_w_data`  in  32  from `RAM.w_data`, current word at `ram_w_addr`.
- `ram_r_data`  in  32  from `RAM.r_data`.

## Operation
- Address decode: `idx = req_addr[LEN+1:2]`, `off = req_addr[1:0]`. Bits above `LEN+1` are ignored, so the address wraps modulo 2^(LEN+2).
- `nbytes` is 1, 2 or 4. The access is single-word if `off + nbytes <= 4`; otherwise it is crossing.
- Little-endian: byte k of the data goes to RAM byte `(off+k) mod 4`.
- FSM states:
  - IDLE: accepts when `req_valid && req_ready`.
  - SECOND: entered only after accepting a crossing access. Holds latched `idx+1` (mod 2^LEN), size, offset, data, `rd`, `we` and `unsigned`. Always returns to IDLE on the next edge.
- Single-word store:
  - `ram_we = 1` in the accept cycle, `ram_w_addr = idx`.
  - `ram_din` = `ram_w_data` with the target bytes replaced by the shifted `req_wdata` bytes.
- Crossing store:
  - Accept cycle writes bytes `off..3` into `idx`.
  - SECOND writes the remaining bytes into `idx+1` at bytes `0..`, merged with `ram_w_data` of that word.
- Single-word load:
  - `ram_r_addr = idx`.
  - Bytes `off..` are extracted from `ram_r_data`, then sign- or zero-extended.
  - Registered into `resp_*` at the accept edge.
- Crossing load:
  - Accept cycle latches `ram_r_data` (word `idx`).
  - SECOND reads `idx+1` and combines high bytes from it with low bytes from the latch.
  - Extends the result and registers `resp_*` at the end of SECOND.
- Illegal size (11):
  - Accepted with no RAM write.
  - Next cycle: `resp_valid=1`, `resp_err=1`, `resp_rdata=0`, `resp_rd=req_rd`. Applies to loads and stores.
- Stores never assert `resp_valid`.
- `ram_we = 0` whenever there is no accepted store and no SECOND-store cycle, and whenever `rst=1`.
- In IDLE with no request, `ram_r_addr` and `ram_w_addr` follow `idx` of `req_addr`; their value is don't-care.

## Timing
- Reset (synchronous): state=IDLE, `resp_valid=0`, `resp_rdata=0`, `resp_rd=0`, `resp_err=0`, latches cleared.
- While `rst=1`: `req_ready=0` and `ram_we=0`.
- Reset asserted during SECOND: the second write/read is suppressed, no `resp_valid`, state goes to IDLE. The first-half write already committed stays in RAM.
- Load latency: `resp_valid` 1 cycle after accept (single-word) or 2 cycles (crossing).
- Throughput: one single-word access per cycle. A crossing access holds `req_ready=0` for exactly one cycle (SECOND).
- `resp_valid` is a one-cycle pulse with no backpressure; all `resp_*` hold their value until the next response.
- Store followed by a load to the same word on the next cycle returns the new data, because the RAM write commits at the edge and the RAM read is async.
- Crossing at the top word (`idx = 2^LEN - 1`): the second part goes to word 0.

## Test plan
- Reset: `rst=1` for 2 cycles with `req_valid=1`, `req_we=1` -> `ram_we=0`, `req_ready=0`, all `resp_*=0`. After release, `req_ready=1`.
- Sub-word loads: sw `0xDEADBEEF` @`0x10`, then:
  - lb @`0x13` -> `0xFFFFFFDE`
  - lbu @`0x13` -> `0x000000DE`
  - lh @`0x12` -> `0xFFFFDEAD`
  - each with `resp_valid` 1 cycle after accept and `resp_rd` echoed.
- Byte merge: sb `0x5A` @`0x11` over `0xDEADBEEF` -> word 4 = `0xDEAD5AEF`. Back-to-back lw @`0x10` next cycle -> `0xDEAD5AEF`.
- Crossing: from zeroed RAM, sw `0x11223344` @`0x22`:
  - word 8 = `0x33440000`, word 9 = `0x00001122`, `req_ready` low for exactly 1 cycle.
  - Then lw @`0x22` -> `0x11223344`, `resp_valid` 2 cycles after accept.
- Wrap: with `LEN=10`, sh `0xABCD` @`0xFFF` -> word 1023 bits[31:24] = `0xCD`, word 0 bits[7:0] = `0xAB`.
- Reset during SECOND: `rst=1` in SECOND of a crossing sw -> only the first word is modified, state returns to IDLE.
- Illegal size: `req_size=11` load -> next cycle `resp_valid=1`, `resp_err=1`, `resp_rdata=0`, and no `ram_we`.
